// File: rtl/reg_bus_arbiter_pkg.sv
// rtl/reg_bus_arbiter_pkg.sv - shared types, defaults and helpers for the register-bus arbiter
//
// Package common
//   arb_state_e      : arbiter FSM states
//   REG_ARB_TIMEOUT  : default number of WAIT cycles before an error response
//   rr_wrap()        : modulo-n wrap of (base + off), used by the round-robin search
package common;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int REG_ARB_TIMEOUT = 8;

    // base < n and 1 <= off <= n, so a single subtraction is enough to wrap.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - single-cycle-ack register bus between the arbiter and a register block
//
// Signals
//   req        : one-cycle bus request (master -> slave)
//   rd_wr      : 1 = read, 0 = write (master -> slave)
//   addr       : register address (master -> slave)
//   write_val  : write data (master -> slave)
//   ack        : completion strobe (slave -> master)
//   read_val   : read data, valid with ack (slave -> master)
interface reg_bus_arbiter_if #(
    parameter int ADDR_SIZE_P = 4,
    parameter int REG_SIZE_P  = 32
);

    logic                   req;
    logic                   rd_wr;
    logic [ADDR_SIZE_P-1:0] addr;
    logic [REG_SIZE_P-1:0]  write_val;
    logic                   ack;
    logic [REG_SIZE_P-1:0]  read_val;

    modport master (
        output req, rd_wr, addr, write_val,
        input  ack, read_val
    );

    modport slave (
        input  req, rd_wr, addr, write_val,
        output ack, read_val
    );

endinterface

// File: rtl/reg_bus_arbiter_rr_arb_pick.sv
// rtl/reg_bus_arbiter_rr_arb_pick.sv - combinational round-robin requester selection
//
// Module rr_arb_pick
//   req_vec     in  NUM_REQ_P  request levels
//   last_grant  in  3          index of the previously granted requester
//   grant       out 3          selected requester index
//   grant_valid out 1          at least one request is pending
module rr_arb_pick
    import common::*;
#(
    parameter int NUM_REQ_P = 2
) (
    input  logic [NUM_REQ_P-1:0] req_vec,
    input  logic [2:0]           last_grant,
    output logic [2:0]           grant,
    output logic                 grant_valid
);

    // Scan from the farthest offset down to last_grant+1; the nearest pending
    // requester is written last and therefore wins. Offset NUM_REQ_P is the
    // last grant itself, so a lone requester can be served repeatedly.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int off = NUM_REQ_P; off >= 1; off--) begin
            for (int j = 0; j < NUM_REQ_P; j++) begin
                if (req_vec[j] && (j == rr_wrap(int'(last_grant), off, NUM_REQ_P))) begin
                    grant       = 3'(j);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter from N requesters onto one register bus
//
// Module reg_bus_arbiter
//   clk, reset_L   : rising-edge clock, asynchronous active-low reset
//   m_req          : per-requester request level, sampled only in IDLE
//   m_rd_wr        : per-requester direction (1 = read)
//   m_addr         : packed addresses, requester i at slice i
//   m_write_val    : packed write data, requester i at slice i
//   m_ack          : one-hot completion pulse (one cycle, in RESP)
//   m_err          : timeout flag, valid with m_ack
//   m_read_val     : shared read data, valid with m_ack
//   bus            : register bus master port
//   busy           : high whenever the FSM is not in IDLE
//   grant_id       : index of the current or last granted requester
module reg_bus_arbiter
    import common::*;
#(
    parameter int NUM_REQ_P   = 2,
    parameter int REG_SIZE_P  = 32,
    parameter int ADDR_SIZE_P = 4,
    parameter int TIMEOUT_P   = REG_ARB_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              reset_L,
    input  logic [NUM_REQ_P-1:0]              m_req,
    input  logic [NUM_REQ_P-1:0]              m_rd_wr,
    input  logic [NUM_REQ_P*ADDR_SIZE_P-1:0]  m_addr,
    input  logic [NUM_REQ_P*REG_SIZE_P-1:0]   m_write_val,
    output logic [NUM_REQ_P-1:0]              m_ack,
    output logic [NUM_REQ_P-1:0]              m_err,
    output logic [REG_SIZE_P-1:0]             m_read_val,
    reg_bus_arbiter_if.master                 bus,
    output logic                              busy,
    output logic [2:0]                        grant_id
);

    arb_state_e             state_q,      state_d;
    logic [7:0]             cnt_q,        cnt_d;
    logic [2:0]             last_q,       last_d;
    logic [2:0]             grant_id_q,   grant_id_d;
    logic                   req_q,        req_d;
    logic                   rd_wr_q,      rd_wr_d;
    logic [ADDR_SIZE_P-1:0] addr_q,       addr_d;
    logic [REG_SIZE_P-1:0]  write_val_q,  write_val_d;
    logic [NUM_REQ_P-1:0]   m_ack_q,      m_ack_d;
    logic [NUM_REQ_P-1:0]   m_err_q,      m_err_d;
    logic [REG_SIZE_P-1:0]  m_read_val_q, m_read_val_d;
    logic                   busy_q,       busy_d;

    logic [2:0]             pick_id;
    logic                   pick_valid;
    logic [NUM_REQ_P-1:0]   grant_onehot;

    rr_arb_pick #(
        .NUM_REQ_P (NUM_REQ_P)
    ) u_pick (
        .req_vec     (m_req),
        .last_grant  (last_q),
        .grant       (pick_id),
        .grant_valid (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        grant_id_d   = grant_id_q;
        req_d        = 1'b0;
        rd_wr_d      = rd_wr_q;
        addr_d       = addr_q;
        write_val_d  = write_val_q;
        m_ack_d      = '0;
        m_err_d      = '0;
        m_read_val_d = m_read_val_q;
        busy_d       = busy_q;

        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ_P; i++) begin
            grant_onehot[i] = (grant_id_q == 3'(i));
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_id;
                    last_d     = pick_id;
                    for (int i = 0; i < NUM_REQ_P; i++) begin
                        if (pick_id == 3'(i)) begin
                            rd_wr_d     = m_rd_wr[i];
                            addr_d      = m_addr[i*ADDR_SIZE_P +: ADDR_SIZE_P];
                            write_val_d = m_write_val[i*REG_SIZE_P +: REG_SIZE_P];
                        end
                    end
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                // ack is checked first so an ack in the last WAIT cycle wins.
                if (bus.ack) begin
                    m_read_val_d = bus.read_val;
                    m_ack_d      = grant_onehot;
                    state_d      = RESP;
                end else if (cnt_q == 8'(TIMEOUT_P - 1)) begin
                    m_read_val_d = '0;
                    m_ack_d      = grant_onehot;
                    m_err_d      = grant_onehot;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 3'(NUM_REQ_P - 1);
            grant_id_q   <= '0;
            req_q        <= 1'b0;
            rd_wr_q      <= 1'b0;
            addr_q       <= '0;
            write_val_q  <= '0;
            m_ack_q      <= '0;
            m_err_q      <= '0;
            m_read_val_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            grant_id_q   <= grant_id_d;
            req_q        <= req_d;
            rd_wr_q      <= rd_wr_d;
            addr_q       <= addr_d;
            write_val_q  <= write_val_d;
            m_ack_q      <= m_ack_d;
            m_err_q      <= m_err_d;
            m_read_val_q <= m_read_val_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req       = req_q;
    assign bus.rd_wr     = rd_wr_q;
    assign bus.addr      = addr_q;
    assign bus.write_val = write_val_q;
    assign m_ack         = m_ack_q;
    assign m_err         = m_err_q;
    assign m_read_val    = m_read_val_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter with a register-block slave model
module tb_reg_bus_arbiter;

    localparam int N = 2;
    localparam int R = 32;
    localparam int A = 4;
    localparam int T = 8;

    logic           clk = 1'b0;
    logic           reset_L = 1'b0;
    logic [N-1:0]   m_req = '0;
    logic [N-1:0]   m_rd_wr = '0;
    logic [N*A-1:0] m_addr = '0;
    logic [N*R-1:0] m_write_val = '0;
    logic [N-1:0]   m_ack;
    logic [N-1:0]   m_err;
    logic [R-1:0]   m_read_val;
    logic           busy;
    logic [2:0]     grant_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.ADDR_SIZE_P(A), .REG_SIZE_P(R)) bus ();

    reg_bus_arbiter #(
        .NUM_REQ_P   (N),
        .REG_SIZE_P  (R),
        .ADDR_SIZE_P (A),
        .TIMEOUT_P   (T)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .m_req       (m_req),
        .m_rd_wr     (m_rd_wr),
        .m_addr      (m_addr),
        .m_write_val (m_write_val),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_read_val  (m_read_val),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    // Register-block slave at address 0: bit 0 = port enable, bits 7:4 = port id (reset 5).
    // ack_dly = cycles from the request edge to the ack edge.
    logic         s_ack;
    logic [R-1:0] s_rdata;
    logic         cfg_port_enable;
    logic [3:0]   cfg_port_id;
    logic [7:0]   pend;
    int           ack_dly = 1;
    logic         ack_force = 1'b0;

    assign bus.ack      = s_ack | ack_force;
    assign bus.read_val = s_rdata;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s_ack           <= 1'b0;
            s_rdata         <= '0;
            cfg_port_enable <= 1'b0;
            cfg_port_id     <= 4'd5;
            pend            <= '0;
        end else begin
            s_ack <= 1'b0;
            if (bus.req && bus.addr == 4'h0 && ack_dly > 1) pend <= 8'(ack_dly - 1);
            else if (pend != 0) pend <= pend - 8'd1;
            if ((bus.req && bus.addr == 4'h0 && ack_dly == 1) || pend == 8'd1) begin
                s_ack <= 1'b1;
                if (bus.rd_wr) s_rdata <= {24'h0, cfg_port_id, 3'b000, cfg_port_enable};
                else begin
                    cfg_port_enable <= bus.write_val[0];
                    cfg_port_id     <= bus.write_val[7:4];
                end
            end
        end
    end

    typedef struct {
        int          id;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wd;
        int          dly;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int cyc;
        logic [N-1:0] oh;
        oh = '0;
        oh[v.id] = 1'b1;
        @(negedge clk);
        ack_dly = v.dly;
        m_rd_wr[v.id] = v.rd;
        m_addr[v.id*A +: A] = v.addr;
        m_write_val[v.id*R +: R] = v.wd;
        m_req[v.id] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (m_ack == '0 && cyc < 40);
        m_req[v.id] = 1'b0;
        check("latency", cyc, v.lat);
        check("m_ack", m_ack, oh);
        check("m_err", m_err, v.exp_err ? oh : '0);
        check("grant_id", grant_id, v.id);
        if (v.rd) check("m_read_val", m_read_val, v.exp_rd);
        @(negedge clk);
        check("ack_one_cycle", m_ack, '0);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int nacks;
        int last_t;

        vecs[0] = '{0, 1'b1, 4'h0, 32'h0,        1, 32'h50, 1'b0, 3};
        vecs[1] = '{1, 1'b0, 4'h0, 32'h000000A1, 1, 32'h0,  1'b0, 3};
        vecs[2] = '{1, 1'b1, 4'h0, 32'h0,        1, 32'hA1, 1'b0, 3};
        vecs[3] = '{0, 1'b1, 4'h3, 32'h0,        1, 32'h0,  1'b1, T + 2};
        vecs[4] = '{0, 1'b1, 4'h0, 32'h0,        1, 32'hA1, 1'b0, 3};
        vecs[5] = '{0, 1'b0, 4'h0, 32'hFFFFFFFF, 1, 32'h0,  1'b0, 3};
        vecs[6] = '{1, 1'b1, 4'h0, 32'h0,        T, 32'hF1, 1'b0, T + 2};
        vecs[7] = '{1, 1'b1, 4'h0, 32'h0,    T + 1, 32'h0,  1'b1, T + 2};
        vecs[8] = '{0, 1'b1, 4'h0, 32'h0,        2, 32'hF1, 1'b0, 4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_req", bus.req, 1'b0);
        check("rst_rd_wr", bus.rd_wr, 1'b0);
        check("rst_addr", bus.addr, 4'h0);
        check("rst_write_val", bus.write_val, 32'h0);
        check("rst_m_ack", m_ack, '0);
        check("rst_m_err", m_err, '0);
        check("rst_m_read_val", m_read_val, 32'h0);
        check("rst_grant_id", grant_id, 3'd0);
        reset_L = 1'b1;

        // Stray ack while IDLE
        @(negedge clk);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        check("idle_ack_busy", busy, 1'b0);
        check("idle_ack_m_ack", m_ack, '0);
        @(negedge clk);
        check("idle_ack_m_ack2", m_ack, '0);

        // Directed transaction table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
            if (i == 2) begin
                check("cfg_port_enable", cfg_port_enable, 1'b1);
                check("cfg_port_id", cfg_port_id, 4'hA);
            end
        end

        // Contention from reset: both requesters held high
        @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        ack_dly = 1;
        m_rd_wr = '1;
        m_addr  = '0;
        m_req   = '1;
        nacks = 0;
        cyc = 0;
        last_t = 0;
        while (nacks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m_ack != '0) begin
                check("cont_grant", m_ack, (nacks % 2 == 0) ? 2'b01 : 2'b10);
                check("cont_gap", cyc - last_t, (nacks == 0) ? 3 : 4);
                last_t = cyc;
                nacks++;
                if (nacks == 4) m_req = '0;
            end
        end
        check("cont_count", nacks, 4);
        @(negedge clk);

        // Reset abort during WAIT (requester 0 was granted last, so only reset puts it first again)
        @(negedge clk);
        m_rd_wr[0] = 1'b1;
        m_addr[3:0] = 4'h3;
        m_req = 2'b01;
        @(negedge clk);
        check("issue_req", bus.req, 1'b1);
        check("issue_addr", bus.addr, 4'h3);
        @(negedge clk);
        check("wait_req", bus.req, 1'b0);
        check("wait_addr", bus.addr, 4'h3);
        check("wait_rd_wr", bus.rd_wr, 1'b1);
        check("wait_busy", busy, 1'b1);
        @(negedge clk);
        reset_L = 1'b0;
        m_addr = '0;
        m_req = 2'b11;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_req", bus.req, 1'b0);
        check("abort_m_ack", m_ack, '0);
        @(negedge clk);
        check("abort_hold_m_ack", m_ack, '0);
        reset_L = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (m_ack == '0 && cyc < 40);
        m_req = '0;
        check("abort_first_grant", m_ack, 2'b01);
        check("abort_first_latency", cyc, 3);
        check("abort_first_err", m_err, '0);
        check("abort_first_data", m_read_val, 32'h50);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
